hilo_muldiv_ctrl: RTL and testbench
===================================

// Module: hilo_muldiv_ctrl
// PURPOSE
//  Sequences the shared multi-cycle multiply and divide engines for the MIPS core and owns the
//  architectural HI/LO registers. Serves MULT/DIV/MFHI/MFLO/MTHI/MTLO one at a time, and raises
//  busy so the main control FSM stalls. Also flags divide-by-zero and engine timeouts.
//  Sits between the control unit/register-file datapath and the Div/Mult engines.
// PARAMETERS
//  DATA_W   32  operand, HI and LO width
//  TIMEOUT  40  max WAIT cycles before abort (divider needs 31)
//  CNT_W    6   watchdog counter width; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  Clock        in   1       system clock; all state updates on posedge
//  Reset        in   1       synchronous, active-high
//  i_OpValid    in   1       op request this cycle
//  i_Op         in   3       0 NOP,1 MULT,2 DIV,3 MFHI,4 MFLO,5 MTHI,6 MTLO (7=NOP)
//  i_A, i_B     in   DATA_W  operands (rs, rt); MTHI/MTLO use i_A
//  o_Busy       out  1       engine op in flight; upstream holds request
//  o_Result     out  DATA_W  MFHI/MFLO data
//  o_ResultVld  out  1       1-cycle pulse with o_Result
//  o_Done       out  1       1-cycle pulse when HI/LO written from an engine
//  o_DivZero    out  1       1-cycle exception pulse
//  o_Timeout    out  1       1-cycle abort pulse
//  o_EngA/o_EngB out DATA_W  latched operands to both engines
//  o_DivStart   out  1       1-cycle start to divider
//  o_MultStart  out  1       1-cycle start to multiplier
//  i_DivStop, i_MultStop in 1 engine completion (level)
//  i_DIVHI, i_DIVLO, i_MULTHI, i_MULTLO in DATA_W engine results
//  i_DivZero    in   1       divider's own zero flag
// BEHAVIOUR
//  Reset: state IDLE; HI=LO=0; counter=0; all outputs 0 (o_Eng* = 0).
//  States: IDLE, START, WAIT.
//  IDLE, i_OpValid:
//   DIV with i_B==0 -> engine not started; o_DivZero=1 next cycle; HI/LO unchanged; stay IDLE.
//   DIV/MULT otherwise -> latch o_EngA/B, go START; o_Busy=1 from next cycle.
//   MFHI/MFLO -> o_Result=HI/LO and o_ResultVld=1 next cycle; stay IDLE.
//   MTHI/MTLO -> HI/LO <= i_A at that edge; stay IDLE.
//   NOP/7 -> no effect.
//  START: assert matching o_*Start for exactly this cycle; clear counter; go WAIT.
//  WAIT: counter++ each cycle. Stop of the selected engine is ignored in the first WAIT cycle
//   (stale-stop guard); from the 2nd WAIT cycle a high stop writes HI/LO from that engine,
//   pulses o_Done, and returns to IDLE. For DIV, i_DivZero high at stop -> o_DivZero pulse too,
//   with HI/LO still written. Stop of the non-selected engine is ignored.
//   Counter==TIMEOUT with no stop -> o_Timeout pulse; HI/LO unchanged; IDLE.
//  Busy: o_Busy=1 in START and WAIT; i_OpValid is ignored while busy (no queueing).
//  Stop and timeout in the same cycle: stop wins; no o_Timeout.
//  Reset mid-op: returns to IDLE next edge; HI/LO cleared; no o_Done.
//  Latency: accept->Start 1 cycle; Done = 1 cycle after qualified stop edge.
//  Counter saturates at TIMEOUT; never wraps.
// STRUCTURE
//  Shared package mips_pkg: op encodings OP_NOP..OP_MTLO and state encodings.
//  One sub-module: hilo_watchdog (clear/enable counter with TIMEOUT compare).
//  HI/LO registers and FSM stay in this module.
// TESTING
//  Reset: all outputs 0; then MFHI gives o_Result=0 and o_ResultVld one cycle after request.
//  DIV 100,7 with engine model, 31-cycle latency: o_DivStart once; o_Busy for 33 cycles;
//   HI=2, LO=14; MFLO -> 14.
//  DIV 5,0: no o_DivStart; o_DivZero pulses once; HI/LO keep prior MTHI 0xAAAA/MTLO 0x5555.
//  Stuck engine (stop never high): o_Timeout after TIMEOUT=40 WAIT cycles; HI/LO unchanged.
//  MULT with stale i_MultStop=1 at start: ignored first WAIT cycle; Done only on next stop.
//  Ops during busy: MTHI issued mid-WAIT is dropped. Reset mid-WAIT: IDLE, HI=LO=0, no o_Done.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: request opcodes and FSM states.
package mips_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_MULT = 3'd1,
    OP_DIV  = 3'd2,
    OP_MFHI = 3'd3,
    OP_MFLO = 3'd4,
    OP_MTHI = 3'd5,
    OP_MTLO = 3'd6,
    OP_RSV  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  function automatic logic is_engine_op(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/hilo_watchdog.sv
// WAIT-cycle counter for the multiply/divide sequencer: cleared in START, counts WAIT cycles,
// saturates at TIMEOUT and flags the first WAIT cycle and the abort cycle.
module hilo_watchdog #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic first,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge Clock) begin
    if (Reset || clr) begin
      count <= '0;
    end else if (en && (count != CNT_W'(TIMEOUT))) begin
      count <= count + CNT_W'(1);
    end
  end

  // The abort fires on the edge at which the counter reaches TIMEOUT, i.e. after TIMEOUT WAIT cycles.
  assign first   = (count == '0);
  assign expired = en && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Sequences the shared multiply/divide engines one op at a time and owns the architectural
// HI/LO registers; busy stalls the main control FSM while an engine op is in flight.
module hilo_muldiv_ctrl
  import mips_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              i_OpValid,
  input  logic [2:0]        i_Op,
  input  logic [DATA_W-1:0] i_A,
  input  logic [DATA_W-1:0] i_B,
  output logic              o_Busy,
  output logic [DATA_W-1:0] o_Result,
  output logic              o_ResultVld,
  output logic              o_Done,
  output logic              o_DivZero,
  output logic              o_Timeout,
  output logic [DATA_W-1:0] o_EngA,
  output logic [DATA_W-1:0] o_EngB,
  output logic              o_DivStart,
  output logic              o_MultStart,
  input  logic              i_DivStop,
  input  logic              i_MultStop,
  input  logic [DATA_W-1:0] i_DIVHI,
  input  logic [DATA_W-1:0] i_DIVLO,
  input  logic [DATA_W-1:0] i_MULTHI,
  input  logic [DATA_W-1:0] i_MULTLO,
  input  logic              i_DivZero
);

  state_e            state;
  op_e               op;
  logic              sel_div;
  logic [DATA_W-1:0] hi_reg;
  logic [DATA_W-1:0] lo_reg;
  logic              wait_first;
  logic              wait_expired;
  logic              stop_sel;
  logic              stop_qual;

  assign op        = op_e'(i_Op);
  assign stop_sel  = sel_div ? i_DivStop : i_MultStop;
  // A stop still high from the previous op must not complete this one.
  assign stop_qual = (state == ST_WAIT) && stop_sel && !wait_first;

  hilo_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .Clock   (Clock),
    .Reset   (Reset),
    .clr     (state == ST_START),
    .en      (state == ST_WAIT),
    .first   (wait_first),
    .expired (wait_expired)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= ST_IDLE;
      sel_div     <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      o_Busy      <= 1'b0;
      o_Result    <= '0;
      o_ResultVld <= 1'b0;
      o_Done      <= 1'b0;
      o_DivZero   <= 1'b0;
      o_Timeout   <= 1'b0;
      o_EngA      <= '0;
      o_EngB      <= '0;
      o_DivStart  <= 1'b0;
      o_MultStart <= 1'b0;
    end else begin
      o_ResultVld <= 1'b0;
      o_Done      <= 1'b0;
      o_DivZero   <= 1'b0;
      o_Timeout   <= 1'b0;
      o_DivStart  <= 1'b0;
      o_MultStart <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_OpValid) begin
            if ((op == OP_DIV) && (i_B == '0)) begin
              o_DivZero <= 1'b1;
            end else if (is_engine_op(op)) begin
              o_EngA      <= i_A;
              o_EngB      <= i_B;
              sel_div     <= (op == OP_DIV);
              o_DivStart  <= (op == OP_DIV);
              o_MultStart <= (op == OP_MULT);
              o_Busy      <= 1'b1;
              state       <= ST_START;
            end else begin
              case (op)
                OP_MFHI: begin
                  o_Result    <= hi_reg;
                  o_ResultVld <= 1'b1;
                end
                OP_MFLO: begin
                  o_Result    <= lo_reg;
                  o_ResultVld <= 1'b1;
                end
                OP_MTHI: hi_reg <= i_A;
                OP_MTLO: lo_reg <= i_A;
                default: ;
              endcase
            end
          end
        end
        ST_START: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A qualified stop takes priority over a coincident timeout.
          if (stop_qual) begin
            hi_reg    <= sel_div ? i_DIVHI : i_MULTHI;
            lo_reg    <= sel_div ? i_DIVLO : i_MULTLO;
            o_Done    <= 1'b1;
            o_DivZero <= sel_div && i_DivZero;
            o_Busy    <= 1'b0;
            state     <= ST_IDLE;
          end else if (wait_expired) begin
            o_Timeout <= 1'b1;
            o_Busy    <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          o_Busy <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl with behavioural divider/multiplier engine models.
module tb_hilo_muldiv_ctrl;
  import mips_pkg::*;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 40;
  localparam int CNT_W   = 6;

  logic              Clock = 1'b0;
  logic              Reset;
  logic              i_OpValid;
  logic [2:0]        i_Op;
  logic [DATA_W-1:0] i_A, i_B;
  logic              o_Busy, o_ResultVld, o_Done, o_DivZero, o_Timeout;
  logic [DATA_W-1:0] o_Result, o_EngA, o_EngB;
  logic              o_DivStart, o_MultStart;
  logic              i_DivStop, i_MultStop;
  logic [DATA_W-1:0] i_DIVHI = '0, i_DIVLO = '0, i_MULTHI = '0, i_MULTLO = '0;
  logic              i_DivZero = 1'b0;

  int checks = 0;
  int failures = 0;

  // Engine models: latency counted from the edge that samples the start pulse.
  logic div_run = 1'b0, mult_run = 1'b0;
  int   div_cnt = 0, mult_cnt = 0;
  int   div_lat = 31, mult_lat = 5;
  logic div_stuck = 1'b0, mult_force = 1'b0;

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (o_DivStart) begin
      div_run <= 1'b1;
      div_cnt <= div_lat;
      i_DIVLO <= (o_EngB != 0) ? o_EngA / o_EngB : '0;
      i_DIVHI <= (o_EngB != 0) ? o_EngA % o_EngB : '0;
    end else if (div_cnt > 0) begin
      div_cnt <= div_cnt - 1;
    end
    if (o_MultStart) begin
      mult_run <= 1'b1;
      mult_cnt <= mult_lat;
      {i_MULTHI, i_MULTLO} <= 64'(o_EngA) * 64'(o_EngB);
    end else if (mult_cnt > 0) begin
      mult_cnt <= mult_cnt - 1;
    end
  end

  assign i_DivStop  = div_run && (div_cnt == 0) && !div_stuck;
  assign i_MultStop = (mult_run && (mult_cnt == 0)) || mult_force;

  hilo_muldiv_ctrl #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .i_OpValid   (i_OpValid),
    .i_Op        (i_Op),
    .i_A         (i_A),
    .i_B         (i_B),
    .o_Busy      (o_Busy),
    .o_Result    (o_Result),
    .o_ResultVld (o_ResultVld),
    .o_Done      (o_Done),
    .o_DivZero   (o_DivZero),
    .o_Timeout   (o_Timeout),
    .o_EngA      (o_EngA),
    .o_EngB      (o_EngB),
    .o_DivStart  (o_DivStart),
    .o_MultStart (o_MultStart),
    .i_DivStop   (i_DivStop),
    .i_MultStop  (i_MultStop),
    .i_DIVHI     (i_DIVHI),
    .i_DIVLO     (i_DIVLO),
    .i_MULTHI    (i_MULTHI),
    .i_MULTLO    (i_MULTLO),
    .i_DivZero   (i_DivZero)
  );

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    i_OpValid = 1'b1;
    i_Op = op;
    i_A = a;
    i_B = b;
    step();
    i_OpValid = 1'b0;
    i_Op = OP_NOP;
  endtask

  task automatic read_hilo(input logic [2:0] op, output logic [31:0] val, output logic vld);
    issue(op, 32'd0, 32'd0);
    val = o_Result;
    vld = o_ResultVld;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    i_OpValid = 1'b0;
    i_Op = OP_NOP;
    i_A = '0;
    i_B = '0;
    step();
    step();
    checks++;
    if ({o_Busy, o_ResultVld, o_Done, o_DivZero, o_Timeout, o_DivStart, o_MultStart} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b required 0000000", {o_Busy, o_ResultVld, o_Done, o_DivZero, o_Timeout, o_DivStart, o_MultStart});
    end
    checks++;
    if (o_Result !== 32'd0) begin failures++; $display("FAIL reset_result: got %0h required 0", o_Result); end
    checks++;
    if ({o_EngA, o_EngB} !== 64'd0) begin failures++; $display("FAIL reset_eng: got %0h/%0h required 0/0", o_EngA, o_EngB); end
    Reset = 1'b0;
    step();
  endtask

  task automatic test_mfhi_after_reset();
    logic [31:0] v;
    logic vl;
    checks++;
    if (o_ResultVld !== 1'b0) begin failures++; $display("FAIL mfhi_idle_vld: got %b required 0", o_ResultVld); end
    read_hilo(OP_MFHI, v, vl);
    checks++;
    if (vl !== 1'b1 || v !== 32'd0) begin failures++; $display("FAIL mfhi_reset: got vld=%b data=%0h required vld=1 data=0", vl, v); end
    step();
    checks++;
    if (o_ResultVld !== 1'b0) begin failures++; $display("FAIL mfhi_pulse: got vld=%b required 0", o_ResultVld); end
  endtask

  task automatic test_div();
    int busy = 0;
    int starts = 0;
    logic done = 1'b0;
    logic [31:0] v;
    logic vl;
    issue(OP_DIV, 32'd100, 32'd7);
    for (int c = 0; c < 80 && !done; c++) begin
      if (o_Busy) busy++;
      if (o_DivStart) starts++;
      step();
      done = o_Done;
    end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL div_done: got %b required 1", done); end
    checks++;
    if (starts != 1) begin failures++; $display("FAIL div_start_count: got %0d required 1", starts); end
    checks++;
    if (busy != 33) begin failures++; $display("FAIL div_busy_cycles: got %0d required 33", busy); end
    step();
    checks++;
    if (o_Done !== 1'b0) begin failures++; $display("FAIL div_done_pulse: got %b required 0", o_Done); end
    read_hilo(OP_MFHI, v, vl);
    checks++;
    if (v !== 32'd2) begin failures++; $display("FAIL div_hi: got %0d required 2", v); end
    read_hilo(OP_MFLO, v, vl);
    checks++;
    if (v !== 32'd14 || vl !== 1'b1) begin failures++; $display("FAIL div_lo: got %0d vld=%b required 14 vld=1", v, vl); end
  endtask

  task automatic test_divzero();
    int zpulses = 0;
    int starts = 0;
    logic [31:0] v;
    logic vl;
    issue(OP_MTHI, 32'hAAAA, 32'd0);
    issue(OP_MTLO, 32'h5555, 32'd0);
    issue(OP_DIV, 32'd5, 32'd0);
    checks++;
    if (o_DivZero !== 1'b1 || o_Busy !== 1'b0 || o_DivStart !== 1'b0) begin
      failures++;
      $display("FAIL divzero_pulse: got dz=%b busy=%b start=%b required 1/0/0", o_DivZero, o_Busy, o_DivStart);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      if (o_DivZero) zpulses++;
      if (o_DivStart || o_Busy) starts++;
    end
    checks++;
    if (zpulses != 0 || starts != 0) begin failures++; $display("FAIL divzero_after: got extra dz=%0d start/busy=%0d required 0/0", zpulses, starts); end
    read_hilo(OP_MFHI, v, vl);
    checks++;
    if (v !== 32'hAAAA) begin failures++; $display("FAIL divzero_hi: got %0h required aaaa", v); end
    read_hilo(OP_MFLO, v, vl);
    checks++;
    if (v !== 32'h5555) begin failures++; $display("FAIL divzero_lo: got %0h required 5555", v); end
  endtask

  task automatic test_timeout();
    int busy = 0;
    int dones = 0;
    logic to = 1'b0;
    logic [31:0] v;
    logic vl;
    div_stuck = 1'b1;
    issue(OP_DIV, 32'd9, 32'd3);
    for (int c = 0; c < 100 && !to; c++) begin
      if (o_Busy) busy++;
      step();
      to = o_Timeout;
      if (o_Done) dones++;
    end
    checks++;
    if (to !== 1'b1) begin failures++; $display("FAIL timeout_seen: got %b required 1", to); end
    checks++;
    if (busy != 41 || dones != 0) begin failures++; $display("FAIL timeout_busy: got busy=%0d done=%0d required 41/0", busy, dones); end
    step();
    checks++;
    if (o_Timeout !== 1'b0 || o_Busy !== 1'b0) begin failures++; $display("FAIL timeout_pulse: got to=%b busy=%b required 0/0", o_Timeout, o_Busy); end
    div_stuck = 1'b0;
    read_hilo(OP_MFHI, v, vl);
    checks++;
    if (v !== 32'hAAAA) begin failures++; $display("FAIL timeout_hi: got %0h required aaaa", v); end
    read_hilo(OP_MFLO, v, vl);
    checks++;
    if (v !== 32'h5555) begin failures++; $display("FAIL timeout_lo: got %0h required 5555", v); end
  endtask

  task automatic test_stop_vs_timeout();
    int busy = 0;
    logic done = 1'b0;
    logic to = 1'b0;
    logic [31:0] v;
    logic vl;
    div_lat = 39;
    issue(OP_DIV, 32'd50, 32'd5);
    for (int c = 0; c < 100 && !done && !to; c++) begin
      if (o_Busy) busy++;
      step();
      done = o_Done;
      to = o_Timeout;
    end
    div_lat = 31;
    checks++;
    if (done !== 1'b1 || to !== 1'b0 || busy != 41) begin
      failures++;
      $display("FAIL stop_vs_timeout: got done=%b to=%b busy=%0d required 1/0/41", done, to, busy);
    end
    step();
    read_hilo(OP_MFLO, v, vl);
    checks++;
    if (v !== 32'd10) begin failures++; $display("FAIL stop_vs_timeout_lo: got %0d required 10", v); end
  endtask

  task automatic test_mult_stale();
    int n = 0;
    logic [31:0] v;
    logic vl;
    mult_force = 1'b1;
    issue(OP_MULT, 32'h0001_0000, 32'h0003_0005);
    checks++;
    if (o_MultStart !== 1'b1 || o_DivStart !== 1'b0) begin failures++; $display("FAIL mult_start: got mult=%b div=%b required 1/0", o_MultStart, o_DivStart); end
    step();
    step();
    checks++;
    if (o_Done !== 1'b0) begin failures++; $display("FAIL mult_stale_stop: got done=%b required 0", o_Done); end
    mult_force = 1'b0;
    while (n < 20 && o_Done !== 1'b1) begin
      step();
      n++;
    end
    checks++;
    if (n != 5) begin failures++; $display("FAIL mult_done_latency: got %0d cycles required 5", n); end
    step();
    read_hilo(OP_MFHI, v, vl);
    checks++;
    if (v !== 32'd3) begin failures++; $display("FAIL mult_hi: got %0h required 3", v); end
    read_hilo(OP_MFLO, v, vl);
    checks++;
    if (v !== 32'h0005_0000) begin failures++; $display("FAIL mult_lo: got %0h required 50000", v); end
  endtask

  task automatic test_busy_drop();
    logic done = 1'b0;
    logic [31:0] v;
    logic vl;
    issue(OP_DIV, 32'd20, 32'd3);
    for (int c = 0; c < 5; c++) step();
    issue(OP_MTHI, 32'hDEAD, 32'd0);
    checks++;
    if (o_Busy !== 1'b1) begin failures++; $display("FAIL busy_hold: got busy=%b required 1", o_Busy); end
    for (int c = 0; c < 80 && !done; c++) begin
      step();
      done = o_Done;
    end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL busy_drop_done: got %b required 1", done); end
    step();
    read_hilo(OP_MFHI, v, vl);
    checks++;
    if (v !== 32'd2) begin failures++; $display("FAIL busy_drop_hi: got %0h required 2", v); end
    read_hilo(OP_MFLO, v, vl);
    checks++;
    if (v !== 32'd6) begin failures++; $display("FAIL busy_drop_lo: got %0h required 6", v); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    int busy = 0;
    logic [31:0] v;
    logic vl;
    issue(OP_MULT, 32'd3, 32'd4);
    for (int c = 0; c < 3; c++) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    checks++;
    if (o_Busy !== 1'b0 || o_MultStart !== 1'b0) begin failures++; $display("FAIL reset_mid_idle: got busy=%b start=%b required 0/0", o_Busy, o_MultStart); end
    for (int c = 0; c < 10; c++) begin
      step();
      if (o_Done) dones++;
      if (o_Busy) busy++;
    end
    checks++;
    if (dones != 0 || busy != 0) begin failures++; $display("FAIL reset_mid_done: got done=%0d busy=%0d required 0/0", dones, busy); end
    read_hilo(OP_MFHI, v, vl);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL reset_mid_hi: got %0h required 0", v); end
    read_hilo(OP_MFLO, v, vl);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL reset_mid_lo: got %0h required 0", v); end
  endtask

  initial begin
    test_reset();
    test_mfhi_after_reset();
    test_div();
    test_divzero();
    test_timeout();
    test_stop_vs_timeout();
    test_mult_stale();
    test_busy_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
